// File: rtl/miner_pkg.sv
// Shared miner definitions: default hash width, count-width helper and
// the per-hash result bundle.
package miner_pkg;

   localparam int HASH_W_DEF = 256;

   function automatic int clog2_cnt(input int w);
      return $clog2(w + 1);
   endfunction

   typedef struct packed {
      logic [clog2_cnt(HASH_W_DEF)-1:0] zeros;
      logic [31:0]                      tag;
      logic                             hit;
   } lz_result_t;

endpackage

// File: rtl/lz_chunk.sv
// Combinational leading-zero count and all-zero flag for one chunk.
// Bit CHUNK_W-1 is counted first.
module lz_chunk
   import miner_pkg::*;
#(
   parameter  int CHUNK_W = 32,
   localparam int CZ_W    = clog2_cnt(CHUNK_W)
) (
   input  logic [CHUNK_W-1:0] i_d,
   output logic [CZ_W-1:0]    o_cz,
   output logic               o_az
);

   // Ascending scan: the highest set bit is the last one to write
   always_comb begin
      o_cz = CZ_W'(CHUNK_W);
      for (int i = 0; i < CHUNK_W; i++) begin
         if (i_d[i]) o_cz = CZ_W'(CHUNK_W - 1 - i);
      end
   end

   assign o_az = ~|i_d;

endmodule

// File: rtl/lz_pipe_checker.sv
// Two-stage leading-zero counter for mined hashes with difficulty hit,
// best-result tracking and a saturating hit counter.
module lz_pipe_checker
   import miner_pkg::*;
#(
   parameter int HASH_W  = HASH_W_DEF,
   parameter int CHUNK_W = 32,
   parameter int TAG_W   = 32,
   parameter int CNT_W   = clog2_cnt(HASH_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [HASH_W-1:0] in_hash,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [CNT_W-1:0]  in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_zeros,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_hit,
   input  logic              clear_best,
   output logic              best_valid,
   output logic [CNT_W-1:0]  best_zeros,
   output logic [TAG_W-1:0]  best_tag,
   output logic [31:0]       hit_count
);

   localparam int NUM_CHUNKS = HASH_W / CHUNK_W;
   localparam int CZ_W       = clog2_cnt(CHUNK_W);

   logic                  r_live;
   logic                  w_adv;
   logic                  w_ohs;
   logic [CZ_W-1:0]       w_cz [NUM_CHUNKS];
   logic [NUM_CHUNKS-1:0] w_az;

   logic                  r_s1_valid;
   logic [CZ_W-1:0]       r_s1_cz [NUM_CHUNKS];
   logic [NUM_CHUNKS-1:0] r_s1_az;
   logic [TAG_W-1:0]      r_s1_tag;
   logic [CNT_W-1:0]      r_s1_tgt;

   logic [CNT_W-1:0]      w_zeros;
   logic                  w_run;
   logic                  w_hit;

   logic                  r_out_valid;
   logic [CNT_W-1:0]      r_out_zeros;
   logic [TAG_W-1:0]      r_out_tag;
   logic                  r_out_hit;

   logic                  r_best_valid;
   logic [CNT_W-1:0]      r_best_zeros;
   logic [TAG_W-1:0]      r_best_tag;
   logic [31:0]           r_hit_count;

   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = r_live && w_adv;
   assign w_ohs    = r_out_valid && out_ready;

   for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
      lz_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
         .i_d  (in_hash[HASH_W-1-k*CHUNK_W -: CHUNK_W]),
         .o_cz (w_cz[k]),
         .o_az (w_az[k])
      );
   end

   // A chunk contributes only while every chunk above it is all-zero
   always_comb begin
      w_zeros = '0;
      w_run   = 1'b1;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         if (w_run) w_zeros = w_zeros + CNT_W'(r_s1_cz[k]);
         w_run = w_run & r_s1_az[k];
      end
   end

   assign w_hit = (w_zeros >= r_s1_tgt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live      <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_az     <= '0;
         r_s1_tag    <= '0;
         r_s1_tgt    <= '0;
         r_out_valid <= 1'b0;
         r_out_zeros <= '0;
         r_out_tag   <= '0;
         r_out_hit   <= 1'b0;
         for (int k = 0; k < NUM_CHUNKS; k++) r_s1_cz[k] <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_adv) begin
            r_s1_valid  <= in_valid && r_live;
            r_s1_az     <= w_az;
            r_s1_tag    <= in_tag;
            r_s1_tgt    <= in_target;
            r_out_valid <= r_s1_valid;
            r_out_zeros <= w_zeros;
            r_out_tag   <= r_s1_tag;
            r_out_hit   <= w_hit;
            for (int k = 0; k < NUM_CHUNKS; k++) r_s1_cz[k] <= w_cz[k];
         end
      end
   end

   // Clear beats a same-cycle delivery; ties keep the earlier tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_valid <= 1'b0;
         r_best_zeros <= '0;
         r_best_tag   <= '0;
         r_hit_count  <= '0;
      end else if (clear_best) begin
         r_best_valid <= 1'b0;
         r_best_zeros <= '0;
         r_best_tag   <= '0;
         r_hit_count  <= '0;
      end else if (w_ohs) begin
         if (!r_best_valid || r_out_zeros > r_best_zeros) begin
            r_best_valid <= 1'b1;
            r_best_zeros <= r_out_zeros;
            r_best_tag   <= r_out_tag;
         end
         if (r_out_hit && r_hit_count != 32'hFFFF_FFFF)
            r_hit_count <= r_hit_count + 32'd1;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_zeros  = r_out_zeros;
   assign out_tag    = r_out_tag;
   assign out_hit    = r_out_hit;
   assign best_valid = r_best_valid;
   assign best_zeros = r_best_zeros;
   assign best_tag   = r_best_tag;
   assign hit_count  = r_hit_count;

endmodule

// File: tb/tb_lz_pipe_checker.sv
// Directed plus randomized bench for lz_pipe_checker against a bitwise
// leading-zero model, a result scoreboard and a best/hit model.
module tb_lz_pipe_checker;
   import miner_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] in_hash;
   logic [31:0]  in_tag;
   logic [8:0]   in_target;
   logic         out_valid;
   logic         out_ready;
   logic [8:0]   out_zeros;
   logic [31:0]  out_tag;
   logic         out_hit;
   logic         clear_best;
   logic         best_valid;
   logic [8:0]   best_zeros;
   logic [31:0]  best_tag;
   logic [31:0]  hit_count;

   lz_pipe_checker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_hash    (in_hash),
      .in_tag     (in_tag),
      .in_target  (in_target),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_zeros  (out_zeros),
      .out_tag    (out_tag),
      .out_hit    (out_hit),
      .clear_best (clear_best),
      .best_valid (best_valid),
      .best_zeros (best_zeros),
      .best_tag   (best_tag),
      .hit_count  (hit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   lz_result_t  q[$];
   int          outcyc[$];
   bit          m_bv;
   int          m_bz;
   logic [31:0] m_bt;
   logic [31:0] m_hc;

   task automatic chk(input string nm, input logic [255:0] obs,
                      input logic [255:0] ex);
      n_cmp++;
      assert (obs === ex) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", nm, obs, ex);
      end
   endtask

   function automatic int ref_lz(input logic [255:0] h);
      for (int i = 255; i >= 0; i--) if (h[i]) return 255 - i;
      return 256;
   endfunction

   function automatic logic [255:0] mkz(input int z);
      logic [255:0] r;
      logic [255:0] b;
      r = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
      if (z >= 256) return '0;
      b = 256'd1 << (255 - z);
      return (r & (b - 256'd1)) | b;
   endfunction

   task automatic model_clear();
      m_bv = 1'b0;
      m_bz = 0;
      m_bt = '0;
      m_hc = '0;
   endtask

   task automatic cycle(output bit acc);
      bit         ohs;
      lz_result_t e;
      int         z;
      #1;
      acc = in_valid && in_ready;
      ohs = out_valid && out_ready;
      if (ohs) begin
         outcyc.push_back(cyc);
         if (q.size() == 0) begin
            chk("spurious_out_valid", out_valid, 1'b0);
         end else begin
            e = q.pop_front();
            chk("out_zeros", out_zeros, e.zeros);
            chk("out_tag", out_tag, e.tag);
            chk("out_hit", out_hit, e.hit);
            if (!clear_best) begin
               if (!m_bv || int'(e.zeros) > m_bz) begin
                  m_bv = 1'b1;
                  m_bz = int'(e.zeros);
                  m_bt = e.tag;
               end
               if (e.hit && m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
            end
         end
      end
      if (clear_best) model_clear();
      if (acc) begin
         z       = ref_lz(in_hash);
         e.zeros = 9'(z);
         e.tag   = in_tag;
         e.hit   = (z >= int'(in_target));
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("best_valid", best_valid, m_bv);
      chk("best_zeros", best_zeros, m_bz);
      chk("best_tag", best_tag, m_bt);
      chk("hit_count", hit_count, m_hc);
   endtask

   task automatic send(input logic [255:0] h, input logic [31:0] t,
                       input logic [8:0] tg);
      bit a;
      a         = 1'b0;
      in_hash   = h;
      in_tag    = t;
      in_target = tg;
      in_valid  = 1'b1;
      for (int i = 0; i < 50 && !a; i++) cycle(a);
      if (!a) chk("accept_timeout", a, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit a;
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0 && !out_valid) break;
         cycle(a);
      end
      chk("drain_empty", q.size(), 0);
      chk("drain_out_valid", out_valid, 1'b0);
   endtask

   task automatic send_chk(input string nm, input logic [255:0] h,
                           input logic [31:0] t, input int ez);
      bit a;
      send(h, t, 9'd0);
      cycle(a);
      chk(nm, out_zeros, ez);
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          a;
      logic [8:0]  sz;
      logic [31:0] st;
      logic        sh;
      int          z;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_hash    = '0;
      in_tag     = '0;
      in_target  = '0;
      out_ready  = 1'b1;
      clear_best = 1'b0;
      model_clear();

      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_zeros", out_zeros, 0);
      chk("rst_best_valid", best_valid, 1'b0);
      chk("rst_hit_count", hit_count, 0);
      #21;
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_pre_edge", in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("rel_in_ready", in_ready, 1'b1);

      // all-zero hash: latency and full count
      send(256'd0, 32'h100, 9'd256);
      chk("lat_n1_out_valid", out_valid, 1'b0);
      cycle(a);
      chk("lat_n2_out_valid", out_valid, 1'b1);
      chk("all0_zeros", out_zeros, 256);
      chk("all0_hit", out_hit, 1'b1);
      drain();

      send_chk("msb_zeros", 256'd1 << 255, 32'h101, 0);
      send_chk("lsb_zeros", 256'd1, 32'h102, 255);
      send_chk("f0_zeros", 256'h0000_0000_0000_00F0 << 192, 32'h103, 56);

      // back-to-back 8
      outcyc.delete();
      for (int i = 0; i < 8; i++) begin
         chk("b2b_in_ready", in_ready, 1'b1);
         send(mkz($urandom_range(0, 256)), 32'h200 + i, 9'($urandom_range(0, 300)));
      end
      drain();
      chk("b2b_count", outcyc.size(), 8);
      if (outcyc.size() >= 8) chk("b2b_consec", outcyc[7] - outcyc[0], 7);

      // stall with A, B inside and C waiting at the input
      out_ready = 1'b0;
      send(mkz(10), 32'hA0, 9'd5);
      send(mkz(77), 32'hB0, 9'd100);
      in_hash   = mkz(3);
      in_tag    = 32'hC0;
      in_target = 9'd3;
      in_valid  = 1'b1;
      sz = out_zeros;
      st = out_tag;
      sh = out_hit;
      chk("stall_out_valid", out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(a);
         chk("stall_accept", a, 1'b0);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_zeros", out_zeros, sz);
         chk("stall_tag", out_tag, st);
         chk("stall_hit", out_hit, sh);
      end
      out_ready = 1'b1;
      a = 1'b0;
      for (int i = 0; i < 10 && !a; i++) cycle(a);
      chk("stall_c_accept", a, 1'b1);
      in_valid = 1'b0;
      drain();

      // best tracking and hit counting
      clear_best = 1'b1;
      cycle(a);
      clear_best = 1'b0;
      send(mkz(20), 32'hA, 9'd30);
      send(mkz(35), 32'hB, 9'd30);
      send(mkz(35), 32'hC, 9'd30);
      send(mkz(12), 32'hD, 9'd30);
      drain();
      chk("best_zeros_35", best_zeros, 35);
      chk("best_tag_B", best_tag, 32'hB);
      chk("hit_count_2", hit_count, 2);
      send(mkz(40), 32'hE, 9'd30);
      for (int i = 0; i < 10 && !out_valid; i++) cycle(a);
      chk("clr_out_valid", out_valid, 1'b1);
      clear_best = 1'b1;
      cycle(a);
      clear_best = 1'b0;
      chk("clr_best_valid", best_valid, 1'b0);
      chk("clr_hit_count", hit_count, 0);
      send_chk("tgt0_zeros", mkz(0), 32'hF, 0);
      send(mkz(256), 32'h10, 9'd300);
      drain();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         z = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 256)
                                         : $urandom_range(0, 40);
         in_valid   = ($urandom_range(0, 3) != 0);
         in_hash    = mkz(z);
         in_tag     = $urandom;
         in_target  = 9'($urandom_range(0, 300));
         out_ready  = ($urandom_range(0, 3) != 0);
         clear_best = ($urandom_range(0, 49) == 0);
         cycle(a);
      end
      in_valid   = 1'b0;
      clear_best = 1'b0;
      out_ready  = 1'b1;
      drain();

      // reset with two hashes in flight
      send(mkz(7), 32'h77, 9'd0);
      send(mkz(9), 32'h99, 9'd0);
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_in_ready", in_ready, 1'b0);
      chk("mrst_out_tag", out_tag, 0);
      chk("mrst_best_valid", best_valid, 1'b0);
      chk("mrst_hit_count", hit_count, 0);
      q.delete();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("mrst_hold_ready", in_ready, 1'b0);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle(a);
         chk("post_rst_out_valid", out_valid, 1'b0);
      end
      chk("post_rst_in_ready", in_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
